// File: rtl/wb_stage_pkg.sv
// Shared core types: datapath widths, the IO-to-WB bus and the WB back-pass bus.
// The three packages are kept in one file so they compile in dependency order.
package cpu_core_params;
    localparam int CPU_DATA_WIDTH         = 32;
    localparam int REGISTER_COUNT         = 32;
    localparam int REGISTER_ADDRESS_WIDTH = $clog2(REGISTER_COUNT);

    typedef logic [CPU_DATA_WIDTH-1:0]         CpuData;
    typedef logic [31:0]                       ProgramCount;
    typedef logic [REGISTER_ADDRESS_WIDTH-1:0] RegisterAddress;
endpackage

package io_stage_params;
    import cpu_core_params::*;

    typedef struct packed {
        logic           valid;
        ProgramCount    program_count;
        CpuData         final_result;
        RegisterAddress register_file_address;
        logic           register_file_write_enabled;
    } IOToWBData;
endpackage

package wb_stage_params;
    import cpu_core_params::*;

    localparam int DEBUG_WRITE_ENABLE_WIDTH = 4;

    typedef struct packed {
        logic           valid;
        RegisterAddress write_register;
        CpuData         write_data;
    } WBToIDBackPassData;
endpackage

// File: rtl/wb_stage_if.sv
// Upstream handshake plus debug trace port of the writeback stage.
// The slave side is the stage itself; the master side is the IO stage / trace consumer.
interface wb_stage_if;
    import cpu_core_params::*;
    import io_stage_params::*;
    import wb_stage_params::*;

    IOToWBData                             io_to_wb_bus;
    logic                                  wb_allow_in;
    logic                                  debug_trace_ready;
    ProgramCount                           debug_program_count;
    logic [DEBUG_WRITE_ENABLE_WIDTH-1:0]   debug_register_write_enable;
    RegisterAddress                        debug_register_write_number;
    CpuData                                debug_register_write_data;

    modport master (
        output io_to_wb_bus,
        output debug_trace_ready,
        input  wb_allow_in,
        input  debug_program_count,
        input  debug_register_write_enable,
        input  debug_register_write_number,
        input  debug_register_write_data
    );

    modport slave (
        input  io_to_wb_bus,
        input  debug_trace_ready,
        output wb_allow_in,
        output debug_program_count,
        output debug_register_write_enable,
        output debug_register_write_number,
        output debug_register_write_data
    );
endinterface

// File: rtl/wb_stage_register_file.sv
// Architectural register file: one write port, two combinational read ports.
// Reads see a same-cycle write (write-first); r0 always reads as zero.
module register_file
    import cpu_core_params::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           write_enable,
    input  RegisterAddress write_address,
    input  CpuData         write_data,
    input  RegisterAddress read_address_1,
    input  RegisterAddress read_address_2,
    output CpuData         read_data_1,
    output CpuData         read_data_2
);

    CpuData registers [REGISTER_COUNT];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGISTER_COUNT; i++) begin
                registers[i] <= '0;
            end
        end else if (write_enable && write_address != '0) begin
            registers[write_address] <= write_data;
        end
    end

    // The bypass lets decode use a value retiring in this very cycle.
    always_comb begin
        read_data_1 = registers[read_address_1];
        if (read_address_1 == '0) begin
            read_data_1 = '0;
        end else if (write_enable && write_address == read_address_1) begin
            read_data_1 = write_data;
        end
    end

    always_comb begin
        read_data_2 = registers[read_address_2];
        if (read_address_2 == '0) begin
            read_data_2 = '0;
        end else if (write_enable && write_address == read_address_2) begin
            read_data_2 = write_data;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one pipeline register, register-file commit, forwarding
// back-pass, debug trace port stalled by debug_trace_ready, retire counter.
module wb_stage
    import cpu_core_params::*, io_stage_params::*, wb_stage_params::*;
(
    input  logic              clock,
    input  logic              reset,
    wb_stage_if.slave         io_wb,
    output WBToIDBackPassData wb_to_id_back_pass_bus,
    input  RegisterAddress    read_address_1,
    input  RegisterAddress    read_address_2,
    output CpuData            read_data_1,
    output CpuData            read_data_2,
    output logic [31:0]       retired_count
);

    logic      wb_valid;
    IOToWBData wb_data;
    logic      wb_ready_go;
    logic      wb_allow_in;
    logic      fire;
    logic      commit_enable;
    logic      unused_captured_valid;

    assign wb_ready_go   = io_wb.debug_trace_ready;
    assign fire          = wb_valid & wb_ready_go;
    assign wb_allow_in   = ~wb_valid | wb_ready_go;
    assign commit_enable = fire & wb_data.register_file_write_enabled
                         & (wb_data.register_file_address != '0);
    assign unused_captured_valid = wb_data.valid;

    assign io_wb.wb_allow_in = wb_allow_in;

    // A bubble clears wb_valid but leaves the previous payload in place.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
        end else if (wb_allow_in) begin
            wb_valid <= io_wb.io_to_wb_bus.valid;
            if (io_wb.io_to_wb_bus.valid) begin
                wb_data <= io_wb.io_to_wb_bus;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_count <= '0;
        end else if (fire) begin
            retired_count <= retired_count + 32'd1;
        end
    end

    register_file u_register_file (
        .clock          (clock),
        .reset          (reset),
        .write_enable   (commit_enable),
        .write_address  (wb_data.register_file_address),
        .write_data     (wb_data.final_result),
        .read_address_1 (read_address_1),
        .read_address_2 (read_address_2),
        .read_data_1    (read_data_1),
        .read_data_2    (read_data_2)
    );

    // Forwarding does not wait for the trace consumer.
    always_comb begin
        wb_to_id_back_pass_bus.valid          = wb_valid & wb_data.register_file_write_enabled;
        wb_to_id_back_pass_bus.write_register = wb_data.register_file_address;
        wb_to_id_back_pass_bus.write_data     = wb_data.final_result;
    end

    always_comb begin
        io_wb.debug_register_write_enable = {DEBUG_WRITE_ENABLE_WIDTH{commit_enable}};
        io_wb.debug_program_count         = '0;
        io_wb.debug_register_write_number = '0;
        io_wb.debug_register_write_data   = '0;
        if (wb_valid) begin
            io_wb.debug_program_count         = wb_data.program_count;
            io_wb.debug_register_write_number = wb_data.register_file_address;
            io_wb.debug_register_write_data   = wb_data.final_result;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: handovers push expected retires, a negedge
// monitor pops them as the trace port retires; directed checks cover the rest.
module tb_wb_stage;
    import cpu_core_params::*;
    import io_stage_params::*;
    import wb_stage_params::*;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  write_enable;
        logic [4:0]  number;
        logic [31:0] data;
        logic        back_pass_valid;
    } RetireExpect;

    logic              clock = 1'b0;
    logic              reset;
    RegisterAddress    read_address_1;
    RegisterAddress    read_address_2;
    CpuData            read_data_1;
    CpuData            read_data_2;
    logic [31:0]       retired_count;
    WBToIDBackPassData back_pass;

    int          checkCount = 0;
    int          errorCount = 0;
    RetireExpect expectedQueue[$];
    RetireExpect expectedRetire;

    wb_stage_if io_wb();

    wb_stage dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_wb                  (io_wb.slave),
        .wb_to_id_back_pass_bus (back_pass),
        .read_address_1         (read_address_1),
        .read_address_2         (read_address_2),
        .read_data_1            (read_data_1),
        .read_data_2            (read_data_2),
        .retired_count          (retired_count)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] address,
                                 input logic [31:0] data, input logic write_enabled);
        RetireExpect e;
        io_wb.io_to_wb_bus.valid                       = 1'b1;
        io_wb.io_to_wb_bus.program_count               = pc;
        io_wb.io_to_wb_bus.final_result                = data;
        io_wb.io_to_wb_bus.register_file_address       = address;
        io_wb.io_to_wb_bus.register_file_write_enabled = write_enabled;
        e.pc              = pc;
        e.write_enable    = (write_enabled && address != 5'd0) ? 4'hF : 4'h0;
        e.number          = address;
        e.data            = data;
        e.back_pass_valid = write_enabled;
        expectedQueue.push_back(e);
    endtask

    task automatic goIdle();
        io_wb.io_to_wb_bus.valid = 1'b0;
    endtask

    task automatic readPort1(input logic [4:0] address, input string name, input logic [31:0] expected);
        read_address_1 = address;
        #1;
        checkOutput(name, read_data_1, expected);
    endtask

    // Monitor: every retire seen on the trace port must match the oldest handover.
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && io_wb.debug_trace_ready === 1'b1 && io_wb.debug_program_count != 32'd0) begin
                if (expectedQueue.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpected_retire: got pc %h, expected no retire", io_wb.debug_program_count);
                end else begin
                    expectedRetire = expectedQueue.pop_front();
                    checkOutput("retire_pc", io_wb.debug_program_count, expectedRetire.pc);
                    checkOutput("retire_we", 32'(io_wb.debug_register_write_enable), 32'(expectedRetire.write_enable));
                    checkOutput("retire_number", 32'(io_wb.debug_register_write_number), 32'(expectedRetire.number));
                    checkOutput("retire_data", io_wb.debug_register_write_data, expectedRetire.data);
                    checkOutput("retire_bp_valid", 32'(back_pass.valid), 32'(expectedRetire.back_pass_valid));
                    checkOutput("retire_bp_reg", 32'(back_pass.write_register), 32'(expectedRetire.number));
                    checkOutput("retire_bp_data", back_pass.write_data, expectedRetire.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset                   = 1'b0;
        io_wb.io_to_wb_bus      = '0;
        io_wb.debug_trace_ready = 1'b1;
        read_address_1          = '0;
        read_address_2          = '0;
        tick();
        tick();

        $display("[TB] reset state");
        for (int pass = 0; pass < 2; pass++) begin
            checkOutput("reset_allow_in", 32'(io_wb.wb_allow_in), 32'd1);
            checkOutput("reset_retired", retired_count, 32'd0);
            checkOutput("reset_dbg_pc", io_wb.debug_program_count, 32'd0);
            checkOutput("reset_dbg_we", 32'(io_wb.debug_register_write_enable), 32'd0);
            checkOutput("reset_bp_valid", 32'(back_pass.valid), 32'd0);
            readPort1(5'd5, "reset_read_r5", 32'd0);
            if (pass == 0) begin
                reset = 1'b1;
                tick();
                tick();
            end
        end

        $display("[TB] single commit");
        applyStimulus(32'hBFC0_0000, 5'd8, 32'h1234_5678, 1'b1);
        tick();
        goIdle();
        checkOutput("commit_dbg_we", 32'(io_wb.debug_register_write_enable), 32'h0000_000F);
        checkOutput("commit_dbg_number", 32'(io_wb.debug_register_write_number), 32'd8);
        tick();
        readPort1(5'd8, "commit_read_r8", 32'h1234_5678);
        read_address_2 = 5'd8;
        #1;
        checkOutput("commit_read2_r8", read_data_2, 32'h1234_5678);
        checkOutput("commit_retired", retired_count, 32'd1);

        $display("[TB] write to r0");
        applyStimulus(32'hBFC0_0004, 5'd0, 32'hFFFF_FFFF, 1'b1);
        tick();
        goIdle();
        checkOutput("r0_dbg_we", 32'(io_wb.debug_register_write_enable), 32'd0);
        readPort1(5'd0, "r0_read_during_retire", 32'd0);
        tick();
        readPort1(5'd0, "r0_read_after", 32'd0);
        checkOutput("r0_retired", retired_count, 32'd2);

        $display("[TB] trace stall");
        io_wb.debug_trace_ready = 1'b0;
        applyStimulus(32'hBFC0_0008, 5'd9, 32'hAAAA_5555, 1'b1);
        tick();
        io_wb.io_to_wb_bus.program_count         = 32'hDEAD_0000;
        io_wb.io_to_wb_bus.register_file_address = 5'd10;
        io_wb.io_to_wb_bus.final_result          = 32'h1111_1111;
        for (int cycle = 0; cycle < 3; cycle++) begin
            checkOutput("stall_allow_in", 32'(io_wb.wb_allow_in), 32'd0);
            checkOutput("stall_dbg_pc", io_wb.debug_program_count, 32'hBFC0_0008);
            checkOutput("stall_dbg_we", 32'(io_wb.debug_register_write_enable), 32'd0);
            checkOutput("stall_bp_valid", 32'(back_pass.valid), 32'd1);
            checkOutput("stall_retired", retired_count, 32'd2);
            readPort1(5'd9, "stall_read_r9", 32'd0);
            tick();
        end
        goIdle();
        io_wb.debug_trace_ready = 1'b1;
        #1;
        checkOutput("stall_release_we", 32'(io_wb.debug_register_write_enable), 32'h0000_000F);
        tick();
        readPort1(5'd9, "stall_read_r9_after", 32'hAAAA_5555);
        readPort1(5'd10, "stall_read_r10_ignored", 32'd0);
        checkOutput("stall_retired_after", retired_count, 32'd3);
        checkOutput("stall_bubble_pc", io_wb.debug_program_count, 32'd0);

        $display("[TB] back-to-back with bypass");
        applyStimulus(32'hBFC0_0010, 5'd3, 32'd1, 1'b1);
        tick();
        applyStimulus(32'hBFC0_0014, 5'd3, 32'd2, 1'b1);
        readPort1(5'd3, "b2b_bypass_first", 32'd1);
        tick();
        goIdle();
        readPort1(5'd3, "b2b_bypass_second", 32'd2);
        tick();
        readPort1(5'd3, "b2b_final_r3", 32'd2);
        checkOutput("b2b_retired", retired_count, 32'd5);

        $display("[TB] retire counter wrap");
        applyStimulus(32'hBFC0_0018, 5'd4, 32'h0000_0044, 1'b1);
        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        #1;
        checkOutput("wrap_preload", retired_count, 32'hFFFF_FFFF);
        tick();
        goIdle();
        tick();
        checkOutput("wrap_retired", retired_count, 32'd0);
        readPort1(5'd4, "wrap_read_r4", 32'h0000_0044);

        $display("[TB] reset during stall");
        io_wb.debug_trace_ready = 1'b0;
        applyStimulus(32'hBFC0_001C, 5'd11, 32'h0BAD_0BAD, 1'b1);
        tick();
        goIdle();
        checkOutput("rst_stall_dbg_pc", io_wb.debug_program_count, 32'hBFC0_001C);
        tick();
        reset = 1'b0;
        #1;
        expectedQueue.delete();
        checkOutput("rst_stall_dbg_pc_cleared", io_wb.debug_program_count, 32'd0);
        checkOutput("rst_stall_allow_in", 32'(io_wb.wb_allow_in), 32'd1);
        checkOutput("rst_stall_bp_valid", 32'(back_pass.valid), 32'd0);
        io_wb.debug_trace_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        readPort1(5'd11, "rst_stall_read_r11", 32'd0);
        checkOutput("rst_stall_retired", retired_count, 32'd0);
        checkOutput("scoreboard_empty", 32'(expectedQueue.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
